// File: rtl/multi_cycle_controller.sv
// Multi-cycle control unit for the ARM-subset datapath: sequences fetch, decode,
// execute, memory and writeback phases and drives every datapath select/enable.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [3:0] rd_i,
  input  logic [3:0] alu_flags_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_a2src_o,
  output logic [1:0] imm_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [3:0] state_o,
  output logic       instr_done_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       pc_we_s, ir_we_s, mem_we_s, reg_we_s;
  logic       cond_ok_s;
  logic [3:0] cmd_s;

  // ARM condition evaluation against stored {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = ~cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cy & ~z;
      4'b1001: cond_pass = ~cy | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cmd_s     = funct_i[4:1];
  assign cond_ok_s = cond_pass(cond_i, flags_q);

  // State and stored-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Next-state, flag update and per-state datapath controls.
  always_comb begin
    state_d      = S_FETCH;
    flags_d      = flags_q;
    pc_we_s      = 1'b0;
    ir_we_s      = 1'b0;
    mem_we_s     = 1'b0;
    reg_we_s     = 1'b0;
    adr_src_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 4'b0000;
    result_src_o = 2'b00;
    instr_done_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_we_s      = 1'b1;
        pc_we_s      = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        alu_op_o     = CMD_ADD;
        result_src_o = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = CMD_ADD;
        if (!cond_ok_s || op_i == 2'b11) begin
          state_d      = S_FETCH;
          instr_done_o = 1'b1;
        end else begin
          case (op_i)
            2'b00:   state_d = funct_i[5] ? S_EXEC_I : S_EXEC_R;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        state_d     = funct_i[0] ? S_MEMRD : S_MEMWR;
        alu_src_b_o = 2'b01;
        alu_op_o    = funct_i[3] ? CMD_ADD : CMD_SUB;
      end
      S_MEMRD: begin
        state_d   = S_MEMWB;
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        state_d      = S_FETCH;
        reg_we_s     = 1'b1;
        pc_we_s      = (rd_i == 4'd15);
        result_src_o = 2'b01;
        instr_done_o = 1'b1;
      end
      S_MEMWR: begin
        state_d      = S_FETCH;
        adr_src_o    = 1'b1;
        mem_we_s     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_b_o = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_op_o    = cmd_s;
        // C and V only carry meaning for the arithmetic commands.
        if (funct_i[0]) begin
          flags_d[3:2] = alu_flags_i[3:2];
          if (cmd_s == CMD_ADD || cmd_s == CMD_SUB || cmd_s == CMD_CMP) begin
            flags_d[1:0] = alu_flags_i[1:0];
          end else begin
            flags_d[1:0] = flags_q[1:0];
          end
        end else begin
          flags_d = flags_q;
        end
        if (cmd_s == CMD_CMP) begin
          state_d      = S_FETCH;
          instr_done_o = 1'b1;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        state_d      = S_FETCH;
        reg_we_s     = 1'b1;
        pc_we_s      = (rd_i == 4'd15);
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        state_d      = S_FETCH;
        pc_we_s      = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b01;
        alu_op_o     = CMD_ADD;
        result_src_o = 2'b10;
        instr_done_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Extender mode and store-data port select depend only on the held IR fields.
  always_comb begin
    case (op_i)
      2'b00:   imm_src_o = 2'b00;
      2'b01:   imm_src_o = 2'b01;
      2'b10:   imm_src_o = 2'b10;
      default: imm_src_o = 2'b11;
    endcase
    reg_a2src_o = (op_i == 2'b01) && !funct_i[0];
  end

  // Write strobes are gated by reset so an aborted instruction writes nothing.
  assign pc_write_o  = pc_we_s  & rst_n;
  assign ir_write_o  = ir_we_s  & rst_n;
  assign mem_write_o = mem_we_s & rst_n;
  assign reg_write_o = reg_we_s & rst_n;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: directed and random instructions against a phase-sequence
// reference model with its own copy of the NZCV flags.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond_i, rd_i, alu_flags_i;
  logic [1:0] op_i;
  logic [5:0] funct_i;
  logic       pc_write_o, ir_write_o, adr_src_o, mem_write_o, reg_write_o, reg_a2src_o;
  logic [1:0] imm_src_o, alu_src_b_o, result_src_o;
  logic       alu_src_a_o, instr_done_o;
  logic [3:0] alu_op_o, state_o;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;
  logic [3:0] flags_m;

  multi_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .cond_i(cond_i), .op_i(op_i), .funct_i(funct_i),
    .rd_i(rd_i), .alu_flags_i(alu_flags_i), .pc_write_o(pc_write_o),
    .ir_write_o(ir_write_o), .adr_src_o(adr_src_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .reg_a2src_o(reg_a2src_o), .imm_src_o(imm_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .result_src_o(result_src_o), .state_o(state_o), .instr_done_o(instr_done_o)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write_o, ir_write_o, adr_src_o, mem_write_o, reg_write_o, reg_a2src_o,
                imm_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, instr_done_o};

  localparam logic [17:0] STROBE_MASK = 18'h36000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Condition test grouped in pairs: odd codes are the inverse of the even code below.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) cond_ok = 1'b0;
    else if (c == 4'b1110) cond_ok = 1'b1;
    else cond_ok = base ^ c[0];
  endfunction

  // Expected control word for one phase; instr_done follows "last cycle of instruction".
  function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic last,
                                          input logic [1:0] o, input logic [5:0] f,
                                          input logic [3:0] r);
    logic pc, ir, adr, mw, rw, a2, sa, dn;
    logic [1:0] imm, sb, rs;
    logic [3:0] aop;
    {pc, ir, adr, mw, rw, sa} = 6'b000000;
    sb = 2'b00; rs = 2'b00; aop = 4'b0000;
    imm = (o == 2'b00) ? 2'b00 : (o == 2'b01) ? 2'b01 : (o == 2'b10) ? 2'b10 : 2'b11;
    a2 = (o == 2'b01) && !f[0];
    dn = last;
    case (st)
      4'd0: begin pc = 1'b1; ir = 1'b1; sa = 1'b1; sb = 2'b10; aop = 4'b0100; rs = 2'b10; end
      4'd1: begin sa = 1'b1; sb = 2'b10; aop = 4'b0100; end
      4'd2: begin sb = 2'b01; aop = f[3] ? 4'b0100 : 4'b0010; end
      4'd3: adr = 1'b1;
      4'd4: begin rw = 1'b1; rs = 2'b01; pc = (r == 4'd15); end
      4'd5: begin adr = 1'b1; mw = 1'b1; end
      4'd6: aop = f[4:1];
      4'd7: begin sb = 2'b01; aop = f[4:1]; end
      4'd8: begin rw = 1'b1; pc = (r == 4'd15); end
      4'd9: begin pc = 1'b1; sa = 1'b1; sb = 2'b01; aop = 4'b0100; rs = 2'b10; end
      default: ;
    endcase
    exp_vec = {pc, ir, adr, mw, rw, a2, imm, sa, sb, aop, rs, dn};
  endfunction

  // Runs one instruction starting in FETCH (entered 2 time units after a rising edge).
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    logic [3:0] seq[$];
    logic pass;
    pass = cond_ok(c, flags_m);
    seq.push_back(4'd0);
    seq.push_back(4'd1);
    if (pass && o == 2'b01) begin
      seq.push_back(4'd2);
      if (f[0]) begin seq.push_back(4'd3); seq.push_back(4'd4); end
      else seq.push_back(4'd5);
    end else if (pass && o == 2'b00) begin
      seq.push_back(f[5] ? 4'd7 : 4'd6);
      if (f[4:1] != 4'b1010) seq.push_back(4'd8);
    end else if (pass && o == 2'b10) begin
      seq.push_back(4'd9);
    end
    cond_i = c; op_i = o; funct_i = f; rd_i = r; alu_flags_i = af;
    for (int k = 0; k < seq.size(); k++) begin
      #2;
      check("state", {28'd0, state_o}, {28'd0, seq[k]});
      check("ctrl", {14'd0, obs}, {14'd0, exp_vec(seq[k], k == seq.size() - 1, o, f, r)});
      @(posedge clk);
      #2;
    end
    if (pass && o == 2'b00 && f[0]) begin
      flags_m[3:2] = af[3:2];
      if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) flags_m[1:0] = af[1:0];
    end
  endtask

  initial begin
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    rst_n = 1'b0; flags_m = 4'b0000;
    cond_i = 4'b1111; op_i = 2'b00; funct_i = 6'b000000; rd_i = 4'd0; alu_flags_i = 4'b0000;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst_state", {28'd0, state_o}, 32'd0);
      check("rst_ctrl", {14'd0, obs}, {14'd0, exp_vec(4'd0, 1'b0, 2'b00, 6'd0, 4'd0) & ~STROBE_MASK});
    end
    rst_n = 1'b1;
    // First instruction after release: never-condition, 2 cycles.
    run_instr(4'b1111, 2'b00, 6'b101000, 4'd2, 4'b0000);
    // ADD immediate, AL, to r2.
    run_instr(4'b1110, 2'b00, 6'b101000, 4'd2, 4'b1111);
    // CMP setting Z, then BEQ taken.
    run_instr(4'b1110, 2'b00, 6'b110101, 4'd0, 4'b0100);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    // CMP clearing Z, then BEQ not taken.
    run_instr(4'b1110, 2'b00, 6'b110101, 4'd0, 4'b0000);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    // LDR to PC, STR, undefined op, never-condition load.
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run_instr(4'b1110, 2'b11, 6'b011001, 4'd3, 4'b1111);
    run_instr(4'b1111, 2'b01, 6'b011001, 4'd3, 4'b1111);
    // Reset during MEMADR of a store must abort with no write.
    cond_i = 4'b1110; op_i = 2'b01; funct_i = 6'b011000; rd_i = 4'd4;
    #2; check("abort_fetch", {28'd0, state_o}, 32'd0);
    @(posedge clk); #2; #2; check("abort_decode", {28'd0, state_o}, 32'd1);
    @(posedge clk); #2; #2; check("abort_memadr", {28'd0, state_o}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("abort_state", {28'd0, state_o}, 32'd0);
    check("abort_strobes", {28'd0, pc_write_o, ir_write_o, mem_write_o, reg_write_o}, 32'd0);
    flags_m = 4'b0000;
    @(posedge clk); #2;
    check("abort_hold", {28'd0, state_o, mem_write_o}, 32'd0);
    rst_n = 1'b1;
    // Z was cleared by the reset, so EQ must now fail.
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) f[4:1] = 4'b1010;
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      run_instr(c, o, f, r, 4'($urandom_range(0, 15)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
